// File: rtl/reg_ctx_seq_pkg.sv
// Shared types and sizing for the register-context sequencer.
// Holds the state encoding and the spill/fill direction codes.
package reg_ctx_pkg;
  localparam int NUM_REGS = 4;
  localparam int RA_W     = 2;
  localparam int DW       = 8;
  localparam int MA_W     = 8;

  localparam logic DIR_SPILL = 1'b0;
  localparam logic DIR_FILL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPILL = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/reg_ctx_seq_if.sv
// Request, register-file and data-memory signals of the context sequencer.
// The master modport is the core side; the sequencer connects through slave.
interface reg_ctx_seq_if;
  import reg_ctx_pkg::*;

  logic            start;
  logic            dir;
  logic [MA_W-1:0] base_addr;
  logic            busy;
  logic            done;
  logic [RA_W-1:0] rf_rd_addr;
  logic [DW-1:0]   rf_rd_data;
  logic            rf_wr_en;
  logic [RA_W-1:0] rf_wr_addr;
  logic [DW-1:0]   rf_wr_data;
  logic [MA_W-1:0] mem_addr;
  logic            mem_wr_en;
  logic [DW-1:0]   mem_wr_data;
  logic [DW-1:0]   mem_rd_data;

  modport master (
    output start, dir, base_addr, rf_rd_data, mem_rd_data,
    input  busy, done, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
           mem_addr, mem_wr_en, mem_wr_data
  );

  modport slave (
    input  start, dir, base_addr, rf_rd_data, mem_rd_data,
    output busy, done, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
           mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/reg_ctx_seq.sv
// Register-context sequencer: spills the register file to memory or fills it back.
// Define REG_CTX_KEEP_R0_EN to leave register 0 (and memory at base+0) untouched.
module reg_ctx_seq
  import reg_ctx_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  reg_ctx_seq_if.slave bus
);

`ifdef REG_CTX_KEEP_R0_EN
  localparam logic [RA_W-1:0] FIRST_IDX = RA_W'(1);
`else
  localparam logic [RA_W-1:0] FIRST_IDX = RA_W'(0);
`endif
  localparam logic [RA_W-1:0] LAST_IDX = RA_W'(NUM_REGS - 1);

  state_t          state;
  logic [RA_W-1:0] idx;
  logic            dir_q;
  logic [MA_W-1:0] base_q;
  logic [MA_W-1:0] xfer_addr;
  logic            xfer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      dir_q  <= DIR_SPILL;
      base_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            base_q <= bus.base_addr;
            dir_q  <= bus.dir;
            idx    <= FIRST_IDX;
            state  <= (bus.dir == DIR_FILL) ? FILL : SPILL;
          end
        end
        SPILL, FILL: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory offset tracks the register index, wrapping modulo the address space.
  assign xfer_addr = base_q + {{(MA_W-RA_W){1'b0}}, idx};
  assign xfer      = (state == SPILL) || (state == FILL);

  always_comb begin
    bus.busy        = xfer;
    bus.done        = (state == DONE);
    bus.rf_rd_addr  = '0;
    bus.rf_wr_en    = 1'b0;
    bus.rf_wr_addr  = '0;
    bus.rf_wr_data  = '0;
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    if (xfer) begin
      bus.mem_addr = xfer_addr;
      if (dir_q == DIR_SPILL) begin
        bus.rf_rd_addr  = idx;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = bus.rf_rd_data;
      end else begin
        bus.rf_wr_en   = 1'b1;
        bus.rf_wr_addr = idx;
        bus.rf_wr_data = bus.mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_ctx_seq.sv
// Scoreboard bench for reg_ctx_seq: stimulus pushes expected writes and done
// timing, a negedge monitor pops and compares against what the DUT presents.
module tb_reg_ctx_seq;
  import reg_ctx_pkg::*;

`ifdef REG_CTX_KEEP_R0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int N_XFER = NUM_REGS - FIRST;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_ctx_seq_if ifc();
  reg_ctx_seq dut (.clk(clk), .reset(reset), .bus(ifc.slave));

  // Environment: register file and data memory that the DUT reads and writes.
  logic [7:0] env_mem [0:255];
  logic [7:0] env_rf  [0:3];
  logic       env_clr, ld_mem_en, ld_rf_en;
  logic [7:0] ld_a, ld_d;

  assign ifc.rf_rd_data  = env_rf[ifc.rf_rd_addr];
  assign ifc.mem_rd_data = env_mem[ifc.mem_addr];

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 8'h00;
      for (int i = 0; i < 4; i++) env_rf[i] <= 8'h00;
    end
    if (ld_mem_en) env_mem[ld_a] <= ld_d;
    if (ld_rf_en) env_rf[ld_a[1:0]] <= ld_d;
    if (ifc.mem_wr_en) env_mem[ifc.mem_addr] <= ifc.mem_wr_data;
    if (ifc.rf_wr_en) env_rf[ifc.rf_wr_addr] <= ifc.rf_wr_data;
  end

  // Reference model of what memory and regfile should hold.
  logic [7:0] ref_mem [0:255];
  logic [7:0] ref_rf  [0:3];

  wr_t exp_mem_q [$];
  wr_t exp_rf_q  [$];
  int  exp_done_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [7:0] a, input logic [7:0] d);
    checks++;
    errors++;
    $display("FAIL %s actual=addr %0h data %0h required=no write", name, a, d);
  endtask

  // Monitor
  always @(negedge clk) begin
    wr_t w;
    if (reset) begin
      busy_run = 0;
    end else begin
      if (ifc.busy) busy_run++;
      if (ifc.mem_wr_en && ifc.rf_wr_en)
        chk("wr_exclusive", {ifc.mem_wr_en, ifc.rf_wr_en}, 2'b01);
      if (ifc.mem_wr_en) begin
        if (exp_mem_q.size() == 0) unexpected("unexpected_mem_wr", ifc.mem_addr, ifc.mem_wr_data);
        else begin
          w = exp_mem_q.pop_front();
          chk("mem_wr_addr", ifc.mem_addr, w.a);
          chk("mem_wr_data", ifc.mem_wr_data, w.d);
        end
      end
      if (ifc.rf_wr_en) begin
        if (exp_rf_q.size() == 0) unexpected("unexpected_rf_wr", 8'(ifc.rf_wr_addr), ifc.rf_wr_data);
        else begin
          w = exp_rf_q.pop_front();
          chk("rf_wr_addr", 8'(ifc.rf_wr_addr), w.a);
          chk("rf_wr_data", ifc.rf_wr_data, w.d);
        end
      end
      if (ifc.done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) unexpected("unexpected_done", 8'h00, 8'h00);
        else chk("done_cycle", cyc, exp_done_q.pop_front());
        chk("busy_cycles", busy_run, N_XFER);
        chk("busy_in_done", ifc.busy, 1'b0);
        busy_run = 0;
      end
    end
  end

  task automatic ld_rf(input int i, input logic [7:0] d);
    @(negedge clk);
    ld_rf_en = 1'b1; ld_a = 8'(i); ld_d = d;
    @(negedge clk);
    ld_rf_en = 1'b0;
    ref_rf[i] = d;
  endtask

  task automatic ld_mem(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_mem_en = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld_mem_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic check_images(input string tag);
    int bad_m, bad_r;
    bad_m = 0; bad_r = 0;
    for (int i = 0; i < 256; i++) if (env_mem[i] !== ref_mem[i]) bad_m++;
    for (int i = 0; i < 4; i++) if (env_rf[i] !== ref_rf[i]) bad_r++;
    chk({tag, "_mem_image_diffs"}, bad_m, 0);
    chk({tag, "_rf_image_diffs"}, bad_r, 0);
  endtask

  task automatic run_xfer(input string tag, input logic d, input logic [7:0] base,
                          input bit toggle, input bit abort);
    wr_t w;
    int  d0, t;
    logic [7:0] a;
    for (int i = FIRST; i < NUM_REGS; i++) begin
      if (abort && i > FIRST) break;
      a = base + 8'(i);
      if (d == DIR_SPILL) begin
        w.a = a; w.d = ref_rf[i];
        exp_mem_q.push_back(w);
        ref_mem[a] = ref_rf[i];
      end else begin
        w.a = 8'(i); w.d = ref_mem[a];
        exp_rf_q.push_back(w);
        ref_rf[i] = ref_mem[a];
      end
    end
    @(negedge clk);
    d0 = done_cnt;
    if (!abort) exp_done_q.push_back(cyc + N_XFER + 1);
    ifc.start = 1'b1; ifc.dir = d; ifc.base_addr = base;
    if (toggle) begin
      // Hold start through the DONE cycle too; it must not restart.
      for (int k = 1; k <= N_XFER + 1; k++) begin
        @(negedge clk);
        ifc.start = (k == N_XFER + 1) ? 1'b1 : 1'($urandom_range(0, 1));
        ifc.dir = ~d;
        ifc.base_addr = 8'h10;
      end
    end
    @(negedge clk);
    ifc.start = 1'b0; ifc.dir = 1'($urandom); ifc.base_addr = 8'($urandom);
    if (abort) begin
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk({tag, "_abort_busy"}, ifc.busy, 1'b0);
      chk({tag, "_abort_mem_wr_en"}, ifc.mem_wr_en, 1'b0);
      chk({tag, "_abort_mem_addr"}, ifc.mem_addr, 8'h00);
      chk({tag, "_abort_done"}, ifc.done, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      chk({tag, "_no_done_after_abort"}, done_cnt, d0);
    end else begin
      t = 0;
      while (done_cnt == d0 && t < 20) begin
        @(negedge clk);
        t++;
      end
      repeat (3) @(negedge clk);
      chk({tag, "_done_count"}, done_cnt, d0 + 1);
    end
    check_images(tag);
  endtask

  initial begin
    reset = 1'b1;
    env_clr = 1'b1; ld_mem_en = 1'b0; ld_rf_en = 1'b0; ld_a = 8'h00; ld_d = 8'h00;
    ifc.start = 1'b0; ifc.dir = 1'b0; ifc.base_addr = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_done", ifc.done, 1'b0);
    chk("rst_mem_wr_en", ifc.mem_wr_en, 1'b0);
    chk("rst_rf_wr_en", ifc.rf_wr_en, 1'b0);
    chk("rst_mem_addr", ifc.mem_addr, 8'h00);
    chk("rst_rf_rd_addr", 32'(ifc.rf_rd_addr), 0);
    env_clr = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", ifc.busy, 1'b0);
    chk("idle_mem_wr_en", ifc.mem_wr_en, 1'b0);

    ld_rf(0, 8'h11); ld_rf(1, 8'h22); ld_rf(2, 8'h33); ld_rf(3, 8'h44);
    run_xfer("spill40", DIR_SPILL, 8'h40, 1'b0, 1'b0);

    ld_mem(8'h80, 8'hA1); ld_mem(8'h81, 8'hB2); ld_mem(8'h82, 8'hC3); ld_mem(8'h83, 8'hD4);
    run_xfer("fill80", DIR_FILL, 8'h80, 1'b0, 1'b0);

    run_xfer("spillFE", DIR_SPILL, 8'hFE, 1'b0, 1'b0);

    ld_rf(0, 8'h5A); ld_rf(1, 8'h6B); ld_rf(2, 8'h7C); ld_rf(3, 8'h8D);
    run_xfer("abort60", DIR_SPILL, 8'h60, 1'b0, 1'b1);
    run_xfer("after_abort", DIR_SPILL, 8'h60, 1'b0, 1'b0);

    ld_rf(0, 8'h01); ld_rf(1, 8'h02); ld_rf(2, 8'h03); ld_rf(3, 8'h04);
    run_xfer("toggle40", DIR_SPILL, 8'h40, 1'b1, 1'b0);

    run_xfer("spill20", DIR_SPILL, 8'h20, 1'b0, 1'b0);

    for (int it = 0; it < 10; it++) begin
      logic       rd;
      logic [7:0] rb;
      rd = 1'($urandom);
      rb = 8'($urandom);
      if (rd == DIR_FILL) begin
        for (int i = 0; i < NUM_REGS; i++) ld_mem(rb + 8'(i), 8'($urandom));
      end else begin
        for (int i = 0; i < NUM_REGS; i++) ld_rf(i, 8'($urandom));
      end
      run_xfer("rand", rd, rb, 1'($urandom), 1'b0);
    end

    chk("mem_q_drained", exp_mem_q.size(), 0);
    chk("rf_q_drained", exp_rf_q.size(), 0);
    chk("done_q_drained", exp_done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
